// File: rtl/axis_pkt_fifo_if.sv
// AXI4-Stream beat channel shared by the axis_pkt_fifo write and read sides.
// Latency: none, this is wiring only.
// Backpressure: tready from the slave side stalls the master side.
// Modports: master drives tvalid/tdata/tkeep/tlast and samples tready;
//           slave samples tvalid/tdata/tkeep/tlast and drives tready.
interface axis_pkt_fifo_if #(
  parameter int DATA_WIDTH = 64,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8
);
  logic                  tvalid;
  logic                  tready;
  logic [DATA_WIDTH-1:0] tdata;
  logic [KEEP_WIDTH-1:0] tkeep;
  logic                  tlast;

  modport master (output tvalid, output tdata, output tkeep, output tlast, input tready);
  modport slave  (input tvalid, input tdata, input tkeep, input tlast, output tready);
endinterface

// File: rtl/axis_pkt_fifo.sv
// Single-clock AXI4-Stream FIFO with optional store-and-forward packet mode.
// Latency: 1 cycle write-to-read in cut-through; first beat 1 cycle after tlast in packet mode.
// Backpressure: s_axis.tready drops when full (forced high while dropping an oversize frame).
// Ports: aclk/areset (sync, active-high); s_axis write channel; m_axis read channel;
//        axis_data_count = stored entries (registered); axis_overflow / axis_underflow /
//        axis_pkt_drop are registered one-cycle status pulses.
module axis_pkt_fifo #(
  parameter int DATA_WIDTH  = 64,
  parameter int KEEP_WIDTH  = DATA_WIDTH / 8,
  parameter int DEPTH       = 16,
  parameter int PACKET_MODE = 1
) (
  input  logic                   aclk,
  input  logic                   areset,
  axis_pkt_fifo_if.slave         s_axis,
  axis_pkt_fifo_if.master        m_axis,
  output logic [$clog2(DEPTH):0] axis_data_count,
  output logic                   axis_overflow,
  output logic                   axis_underflow,
  output logic                   axis_pkt_drop
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int EW = 1 + KEEP_WIDTH + DATA_WIDTH;

  // Pointers carry one extra MSB so full and empty are distinguishable.
  typedef logic [PW-1:0] ptr_t;
  localparam ptr_t PTR_ONE   = ptr_t'(1);
  localparam ptr_t PTR_DEPTH = ptr_t'(DEPTH);

  typedef enum logic {
    ST_PASS = 1'b0,
    ST_DROP = 1'b1
  } state_t;

  // Entry layout: {tlast, tkeep, tdata}
  logic [EW-1:0] mem_q [DEPTH];

  ptr_t   wr_ptr_q, wr_ptr_d;
  ptr_t   rd_ptr_q, rd_ptr_d;
  ptr_t   commit_ptr_q, commit_ptr_d;
  ptr_t   count_q, count_d;
  state_t state_q, state_d;
  logic   overflow_q, overflow_d;
  logic   underflow_q, underflow_d;
  logic   drop_q, drop_d;

  logic          full;
  logic          wr_acc;
  logic          rd_acc;
  logic          m_vld;
  logic          mem_we;
  logic [EW-1:0] rd_word;

  assign full = (ptr_t'(wr_ptr_q - rd_ptr_q) == PTR_DEPTH);

  // While dropping, beats are swallowed regardless of occupancy so the
  // remainder of the oversize frame can never stall the producer.
  assign s_axis.tready = (state_q == ST_DROP) || !full;
  assign wr_acc        = s_axis.tvalid && s_axis.tready;

  // Only committed entries are visible; in cut-through commit follows wr.
  assign m_vld   = (rd_ptr_q != commit_ptr_q);
  assign rd_acc  = m_vld && m_axis.tready;
  assign rd_word = mem_q[rd_ptr_q[AW-1:0]];

  // Outputs are zeroed when nothing is visible so stale RAM never leaks out.
  assign m_axis.tvalid = m_vld;
  assign m_axis.tdata  = m_vld ? rd_word[DATA_WIDTH-1:0] : '0;
  assign m_axis.tkeep  = m_vld ? rd_word[DATA_WIDTH +: KEEP_WIDTH] : '0;
  assign m_axis.tlast  = m_vld && rd_word[EW-1];

  assign axis_data_count = count_q;
  assign axis_overflow   = overflow_q;
  assign axis_underflow  = underflow_q;
  assign axis_pkt_drop   = drop_q;

  assign mem_we = wr_acc && (state_q == ST_PASS);

  // Storage array: no reset needed, visibility is governed by the pointers.
  always_ff @(posedge aclk) begin
    if (mem_we) begin
      mem_q[wr_ptr_q[AW-1:0]] <= {s_axis.tlast, s_axis.tkeep, s_axis.tdata};
    end
  end

  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    commit_ptr_d = commit_ptr_q;
    drop_d       = 1'b0;
    rd_ptr_d     = rd_acc ? ptr_t'(rd_ptr_q + PTR_ONE) : rd_ptr_q;

    case (state_q)
      ST_PASS: begin
        if (wr_acc) begin
          wr_ptr_d = ptr_t'(wr_ptr_q + PTR_ONE);
          if (PACKET_MODE != 0) begin
            if (s_axis.tlast) begin
              commit_ptr_d = ptr_t'(wr_ptr_q + PTR_ONE);
            end else if (ptr_t'(wr_ptr_q + PTR_ONE - commit_ptr_q) == PTR_DEPTH) begin
              // The open frame now fills the whole RAM and still has no
              // tlast: it can never be committed, so rewind and discard.
              wr_ptr_d = commit_ptr_q;
              state_d  = ST_DROP;
              drop_d   = 1'b1;
            end
          end
        end
      end
      ST_DROP: begin
        if (wr_acc && s_axis.tlast) begin
          state_d = ST_PASS;
        end
      end
      default: state_d = ST_PASS;
    endcase

    if (PACKET_MODE == 0) begin
      commit_ptr_d = wr_ptr_d;
    end
  end

  // Status is computed from next-state pointers so the count reflects a
  // transfer in the cycle right after it happens.
  assign count_d     = ptr_t'(wr_ptr_d - rd_ptr_d);
  assign overflow_d  = s_axis.tvalid && !s_axis.tready;
  assign underflow_d = m_axis.tready && !m_vld;

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q      <= ST_PASS;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      commit_ptr_q <= '0;
      count_q      <= '0;
      overflow_q   <= 1'b0;
      underflow_q  <= 1'b0;
      drop_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      commit_ptr_q <= commit_ptr_d;
      count_q      <= count_d;
      overflow_q   <= overflow_d;
      underflow_q  <= underflow_d;
      drop_q       <= drop_d;
    end
  end

endmodule

// File: tb/tb_axis_pkt_fifo.sv
// Testbench for axis_pkt_fifo: one cut-through and one store-and-forward instance.
// Latency: expected beats are queued at drive time and popped as the DUT emits them.
// Backpressure: the driver holds each beat until the DUT raises s_axis.tready.
module tb_axis_pkt_fifo;

  typedef logic [72:0] beat_t;

  logic       aclk = 1'b0;
  logic       areset = 1'b1;
  logic [4:0] cnt0, cnt1;
  logic       ovf0, unf0, drp0, ovf1, unf1, drp1;

  int n_checks = 0;
  int n_pass   = 0;
  int out1     = 0;
  int drops1   = 0;

  beat_t q0[$];
  beat_t q1[$];
  beat_t exp0, exp1;

  axis_pkt_fifo_if #(.DATA_WIDTH(64)) s0 ();
  axis_pkt_fifo_if #(.DATA_WIDTH(64)) m0 ();
  axis_pkt_fifo_if #(.DATA_WIDTH(64)) s1 ();
  axis_pkt_fifo_if #(.DATA_WIDTH(64)) m1 ();

  axis_pkt_fifo #(.DATA_WIDTH(64), .DEPTH(16), .PACKET_MODE(0)) u_ct (
    .aclk            (aclk),
    .areset          (areset),
    .s_axis          (s0.slave),
    .m_axis          (m0.master),
    .axis_data_count (cnt0),
    .axis_overflow   (ovf0),
    .axis_underflow  (unf0),
    .axis_pkt_drop   (drp0)
  );

  axis_pkt_fifo #(.DATA_WIDTH(64), .DEPTH(16), .PACKET_MODE(1)) u_sf (
    .aclk            (aclk),
    .areset          (areset),
    .s_axis          (s1.slave),
    .m_axis          (m1.master),
    .axis_data_count (cnt1),
    .axis_overflow   (ovf1),
    .axis_underflow  (unf1),
    .axis_pkt_drop   (drp1)
  );

  always #5 aclk = ~aclk;

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  // Present one beat and hold it until accepted; returns just after the accepting edge.
  task automatic drive_beat(input bit sel, input logic [63:0] d, input logic [7:0] k,
                            input logic l, input bit keep_exp);
    bit done;
    done = 1'b0;
    #1;
    if (!sel) begin
      s0.tvalid = 1'b1; s0.tdata = d; s0.tkeep = k; s0.tlast = l;
      if (keep_exp) q0.push_back({l, k, d});
    end else begin
      s1.tvalid = 1'b1; s1.tdata = d; s1.tkeep = k; s1.tlast = l;
      if (keep_exp) q1.push_back({l, k, d});
    end
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge aclk);
      done = sel ? s1.tready : s0.tready;
      @(posedge aclk);
    end
    check_val("s_accept", 128'(done), 128'(1));
  endtask

  task automatic release_s(input bit sel);
    #1;
    if (!sel) begin s0.tvalid = 1'b0; s0.tlast = 1'b0; end
    else begin s1.tvalid = 1'b0; s1.tlast = 1'b0; end
  endtask

  task automatic wait_neg(input int n);
    repeat (n) @(negedge aclk);
  endtask

  // Output scoreboards: every handshake must match the head of the queue.
  always @(negedge aclk) begin
    if (!areset && m0.tvalid && m0.tready) begin
      check_val("ct_q_nonempty", 128'(q0.size() != 0), 128'(1));
      if (q0.size() != 0) begin
        exp0 = q0.pop_front();
        check_val("ct_beat", 128'({m0.tlast, m0.tkeep, m0.tdata}), 128'(exp0));
      end
    end
  end

  always @(negedge aclk) begin
    if (!areset && m1.tvalid && m1.tready) begin
      out1++;
      check_val("sf_q_nonempty", 128'(q1.size() != 0), 128'(1));
      if (q1.size() != 0) begin
        exp1 = q1.pop_front();
        check_val("sf_beat", 128'({m1.tlast, m1.tkeep, m1.tdata}), 128'(exp1));
      end
    end
    if (drp1) drops1++;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    int o0;
    s0.tvalid = 0; s0.tdata = '0; s0.tkeep = '0; s0.tlast = 0;
    s1.tvalid = 0; s1.tdata = '0; s1.tkeep = '0; s1.tlast = 0;
    m0.tready = 0; m1.tready = 0;

    repeat (3) @(posedge aclk);
    #1 areset = 1'b0;
    @(negedge aclk);
    check_val("rst_count", 128'(cnt0), 128'(0));
    check_val("rst_mvalid", 128'(m0.tvalid), 128'(0));
    check_val("rst_sready0", 128'(s0.tready), 128'(1));
    check_val("rst_sready1", 128'(s1.tready), 128'(1));
    check_val("rst_flags", 128'({ovf0, unf0, drp1}), 128'(0));

    // Cut-through: four beats held back, then released in order.
    @(posedge aclk);
    for (int i = 0; i < 4; i++)
      drive_beat(1'b0, 64'(i + 1) * 64'h1111_1111_1111_1111, 8'hFF, i == 3, 1'b1);
    release_s(1'b0);
    @(negedge aclk);
    check_val("t1_count", 128'(cnt0), 128'(4));
    check_val("t1_visible", 128'(m0.tvalid), 128'(1));
    @(posedge aclk); #1 m0.tready = 1'b1;
    wait_neg(6);
    check_val("t1_empty", 128'(m0.tvalid), 128'(0));
    check_val("t1_count0", 128'(cnt0), 128'(0));
    check_val("t1_drained", 128'(q0.size()), 128'(0));

    // Underflow while empty with tready high, then clears.
    check_val("t6_underflow", 128'(unf0), 128'(1));
    @(posedge aclk); #1 m0.tready = 1'b0;
    wait_neg(2);
    check_val("t6_underflow_clr", 128'(unf0), 128'(0));

    // Simultaneous read and write at count 5.
    @(posedge aclk);
    for (int i = 0; i < 5; i++)
      drive_beat(1'b0, 64'hB000 + 64'(i), 8'h0F << i, i == 2, 1'b1);
    release_s(1'b0);
    @(negedge aclk);
    check_val("t6_count5", 128'(cnt0), 128'(5));
    @(posedge aclk);
    #1 s0.tvalid = 1'b1; s0.tdata = 64'hB005; s0.tkeep = 8'h3C; s0.tlast = 1'b1;
    q0.push_back({1'b1, 8'h3C, 64'hB005});
    m0.tready = 1'b1;
    @(posedge aclk);
    #1 s0.tvalid = 1'b0; s0.tlast = 1'b0; m0.tready = 1'b0;
    @(negedge aclk);
    check_val("t6_count_hold", 128'(cnt0), 128'(5));
    @(posedge aclk); #1 m0.tready = 1'b1;
    wait_neg(10);
    check_val("t6_count0", 128'(cnt0), 128'(0));
    check_val("t6_drained", 128'(q0.size()), 128'(0));

    // Full: 16 beats, then a stalled 17th beat.
    @(posedge aclk); #1 m0.tready = 1'b0;
    for (int i = 0; i < 16; i++)
      drive_beat(1'b0, 64'hA000 + 64'(i), 8'hFF, i == 15, 1'b1);
    #1 s0.tvalid = 1'b1; s0.tdata = 64'hA010; s0.tkeep = 8'h01; s0.tlast = 1'b1;
    q0.push_back({1'b1, 8'h01, 64'hA010});
    @(negedge aclk);
    check_val("t3_sready_full", 128'(s0.tready), 128'(0));
    check_val("t3_count16", 128'(cnt0), 128'(16));
    @(negedge aclk);
    check_val("t3_overflow_a", 128'(ovf0), 128'(1));
    @(negedge aclk);
    check_val("t3_overflow_b", 128'(ovf0), 128'(1));
    @(posedge aclk); #1 m0.tready = 1'b1;
    @(posedge aclk); #1 m0.tready = 1'b0;
    @(negedge aclk);
    check_val("t3_sready_back", 128'(s0.tready), 128'(1));
    check_val("t3_count15", 128'(cnt0), 128'(15));
    @(posedge aclk); #1 s0.tvalid = 1'b0; s0.tlast = 1'b0;
    @(negedge aclk);
    check_val("t3_overflow_clr", 128'(ovf0), 128'(0));
    check_val("t3_count_refill", 128'(cnt0), 128'(16));
    @(posedge aclk); #1 m0.tready = 1'b1;
    wait_neg(20);
    check_val("t3_count0", 128'(cnt0), 128'(0));
    check_val("t3_drained", 128'(q0.size()), 128'(0));
    @(posedge aclk); #1 m0.tready = 1'b0;

    // Store-and-forward: nothing visible until tlast is written.
    @(posedge aclk); #1 m1.tready = 1'b1;
    drive_beat(1'b1, 64'hC000, 8'hFF, 1'b0, 1'b1);
    release_s(1'b1);
    @(negedge aclk);
    check_val("t2_hidden_a", 128'(m1.tvalid), 128'(0));
    @(posedge aclk);
    drive_beat(1'b1, 64'hC001, 8'hF0, 1'b0, 1'b1);
    release_s(1'b1);
    @(negedge aclk);
    check_val("t2_hidden_b", 128'(m1.tvalid), 128'(0));
    @(posedge aclk);
    drive_beat(1'b1, 64'hC002, 8'h07, 1'b1, 1'b1);
    release_s(1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge aclk);
      check_val("t2_stream", 128'(m1.tvalid), 128'(1));
    end
    @(negedge aclk);
    check_val("t2_done", 128'(m1.tvalid), 128'(0));
    check_val("t2_drained", 128'(q1.size()), 128'(0));

    // Oversize frame after a committed 2-beat frame.
    @(posedge aclk); #1 m1.tready = 1'b0;
    drive_beat(1'b1, 64'hD000, 8'hFF, 1'b0, 1'b1);
    drive_beat(1'b1, 64'hD001, 8'h0F, 1'b1, 1'b1);
    release_s(1'b1);
    @(negedge aclk);
    check_val("t4_count2", 128'(cnt1), 128'(2));
    check_val("t4_visible", 128'(m1.tvalid), 128'(1));
    d0 = drops1;
    @(posedge aclk); #1 m1.tready = 1'b1;
    for (int i = 0; i < 20; i++)
      drive_beat(1'b1, 64'hE000 + 64'(i), 8'hFF, i == 19, 1'b0);
    release_s(1'b1);
    wait_neg(5);
    check_val("t4_drop_once", 128'(drops1 - d0), 128'(1));
    check_val("t4_count0", 128'(cnt1), 128'(0));
    check_val("t4_none_visible", 128'(m1.tvalid), 128'(0));
    check_val("t4_drained", 128'(q1.size()), 128'(0));
    @(posedge aclk);
    drive_beat(1'b1, 64'hD100, 8'hAA, 1'b1, 1'b1);
    release_s(1'b1);
    wait_neg(4);
    check_val("t4_recover", 128'(q1.size()), 128'(0));

    // Reset in the middle of an uncommitted frame.
    @(posedge aclk); #1 m1.tready = 1'b0;
    drive_beat(1'b1, 64'hF000, 8'hFF, 1'b0, 1'b0);
    drive_beat(1'b1, 64'hF001, 8'hFF, 1'b0, 1'b0);
    release_s(1'b1);
    areset = 1'b1;
    @(posedge aclk); #1 areset = 1'b0;
    @(negedge aclk);
    check_val("t5_mvalid", 128'(m1.tvalid), 128'(0));
    check_val("t5_count", 128'(cnt1), 128'(0));
    check_val("t5_mbus", 128'({m1.tlast, m1.tkeep, m1.tdata}), 128'(0));
    check_val("t5_flags", 128'({ovf1, unf1, drp1}), 128'(0));
    check_val("t5_sready", 128'(s1.tready), 128'(1));
    o0 = out1;
    @(posedge aclk); #1 m1.tready = 1'b1;
    drive_beat(1'b1, 64'h5A5A, 8'h33, 1'b1, 1'b1);
    release_s(1'b1);
    wait_neg(5);
    check_val("t5_single_beat", 128'(out1 - o0), 128'(1));
    check_val("t5_drained", 128'(q1.size()), 128'(0));
    check_val("final_q0", 128'(q0.size()), 128'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
